// File: rtl/mem_port_if.sv
// rtl/mem_port_if.sv - request/response bundle between the control FSM and the memory port
interface mem_port_if;
    logic        req;
    logic        we;
    logic        ir_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] mdr;
    logic [31:0] instr;

    // Core side: issues requests, consumes handshake and registers
    modport master (
        output req, we, ir_write, addr, wdata,
        input  ready, done, err, mdr, instr
    );

    // Memory side: accepts requests, drives handshake and registers
    modport slave (
        input  req, we, ir_write, addr, wdata,
        output ready, done, err, mdr, instr
    );
endinterface

// File: rtl/mem_port.sv
// rtl/mem_port.sv - shared instruction/data RAM port with wait states and ready/done handshake
module mem_port #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    mem_port_if.slave  bus
);
    localparam int          AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept;
    logic            access;

    // Request fields captured at acceptance; only the word-index and byte-offset bits matter
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic            ir_write_q;

    logic            done_q;
    logic            err_q;
    logic [31:0]     mdr_q;
    logic [31:0]     instr_q;

    logic [31:0]     ram [DEPTH];

    logic [AW-1:0]   idx;
    logic            misaligned;

    // Upper address bits wrap away by design
    logic            unused_addr;
    assign unused_addr = ^bus.addr[31:AW+2];

    assign idx        = addr_q[AW+1:2];
    assign misaligned = (addr_q[1:0] != 2'b00);

    // State and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, access when the count reaches zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept  = 1'b1;
                    cnt_d   = LAT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request at acceptance so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            ir_write_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= bus.addr[AW+1:0];
            wdata_q    <= bus.wdata;
            we_q       <= bus.we;
            ir_write_q <= bus.ir_write;
        end
    end

    // RAM write; a store cancelled by reset on its access edge must not land
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && !misaligned) begin
            ram[idx] <= wdata_q;
        end
    end

    // Completion pulses and the MDR/IR registers loaded on aligned loads
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mdr_q   <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            done_q <= access;
            err_q  <= access && misaligned;
            if (access && !we_q && !misaligned) begin
                mdr_q <= ram[idx];
                if (ir_write_q) begin
                    instr_q <= ram[idx];
                end
            end
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.mdr   = mdr_q;
    assign bus.instr = instr_q;
endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - randomized self-checking bench for mem_port at LATENCY 2 and 0
module tb_mem_port;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_if bus2();
    mem_port_if bus0();

    mem_port #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mem_port #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    int vectors    = 0;
    int miscompares = 0;

    // Reference model, index 0 = LATENCY 0 instance, index 1 = LATENCY 2 instance
    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] mdr_m   [2];
    logic [31:0] instr_m [2];

    function automatic int lat_of(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a % 32'(4 * DEPTH)) / 32'd4);
    endfunction

    task automatic model_access(input int sel, input logic w, input logic irw,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic exp_err);
        exp_err = (a % 4) != 0;
        if (!exp_err) begin
            if (w) mem_m[sel][widx(a)] = d;
            else begin
                mdr_m[sel] = mem_m[sel][widx(a)];
                if (irw) instr_m[sel] = mem_m[sel][widx(a)];
            end
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w, input logic irw,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 1) begin
            bus2.req = r; bus2.we = w; bus2.ir_write = irw; bus2.addr = a; bus2.wdata = d;
        end else begin
            bus0.req = r; bus0.we = w; bus0.ir_write = irw; bus0.addr = a; bus0.wdata = d;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic dn, output logic er,
                          output logic [31:0] m, output logic [31:0] i);
        if (sel == 1) begin
            rdy = bus2.ready; dn = bus2.done; er = bus2.err; m = bus2.mdr; i = bus2.instr;
        end else begin
            rdy = bus0.ready; dn = bus0.done; er = bus0.err; m = bus0.mdr; i = bus0.instr;
        end
    endtask

    // Runs one access from an idle port; reports observations, checks nothing itself
    task automatic run_access(input int sel, input logic w, input logic irw,
                              input logic [31:0] a, input logic [31:0] d, input bit wiggle,
                              output int lat, output int rlow, output int ndone,
                              output logic er, output logic [31:0] m, output logic [31:0] i);
        logic rdy, dn, e;
        logic [31:0] sm, si;
        lat = -1; rlow = 0; ndone = 0; er = 1'bx; m = 'x; i = 'x;
        drive(sel, 1'b1, w, irw, a, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, w, irw, a, d);
        for (int k = 0; k < 50; k++) begin
            sample(sel, rdy, dn, e, sm, si);
            if (!rdy) rlow++;
            if (dn === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; er = e; m = sm; i = si;
                end
            end
            if (lat >= 0 && k > lat) break;
            if (wiggle && !rdy)
                drive(sel, k == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom, $urandom);
            else
                drive(sel, 1'b0, w, irw, a, d);
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        logic rdy, dn, e;
        logic [31:0] m, i;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, dn, e, m, i);
            vectors++;
            if ({rdy, dn, e} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_flags dut%0d: got rdy/done/err=%b%b%b expected 100", s, rdy, dn, e);
            end
            vectors++;
            if (m !== 32'd0 || i !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_regs dut%0d: got mdr=%h instr=%h expected 0/0", s, m, i);
            end
            mdr_m[s] = 32'd0;
            instr_m[s] = 32'd0;
        end
    endtask

    task automatic test_preload;
        int lat, rlow, nd, bad;
        logic er, ee;
        logic [31:0] m, i, d;
        bad = 0;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < DEPTH; w++) begin
                d = $urandom;
                run_access(s, 1'b1, 1'b0, 32'(w * 4), d, 1'b0, lat, rlow, nd, er, m, i);
                model_access(s, 1'b1, 1'b0, 32'(w * 4), d, ee);
                if (lat != lat_of(s) + 1 || er !== 1'b0) bad++;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL preload: got %0d bad store completions expected 0", bad);
        end
    endtask

    task automatic test_reset_busy;
        logic rdy, dn, e, ee;
        logic [31:0] m, i;
        int lat, rlow, nd;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            sample(1, rdy, dn, e, m, i);
            vectors++;
            if (dn !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_busy_done: got %b expected 0", dn);
            end
        end
        rst = 1'b0;
        sample(1, rdy, dn, e, m, i);
        vectors++;
        if (rdy !== 1'b1 || m !== 32'd0 || i !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_busy_state: got rdy=%b mdr=%h instr=%h expected 1/0/0", rdy, m, i);
        end
        for (int s = 0; s < 2; s++) begin mdr_m[s] = 32'd0; instr_m[s] = 32'd0; end
        @(posedge clk); #1;
        sample(1, rdy, dn, e, m, i);
        vectors++;
        if (dn !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_busy_late_done: got %b expected 0", dn);
        end
        run_access(1, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, lat, rlow, nd, e, m, i);
        model_access(1, 1'b0, 1'b0, 32'h10, 32'd0, ee);
        vectors++;
        if (m !== mdr_m[1]) begin
            miscompares++;
            $display("FAIL rst_busy_ram: got %h expected %h", m, mdr_m[1]);
        end
    endtask

    task automatic test_fetch;
        int lat, rlow, nd;
        logic er, ee;
        logic [31:0] m, i;
        run_access(1, 1'b1, 1'b0, 32'h0C, 32'h8C220004, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b1, 1'b0, 32'h0C, 32'h8C220004, ee);
        run_access(1, 1'b0, 1'b1, 32'h0C, 32'd0, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b0, 1'b1, 32'h0C, 32'd0, ee);
        vectors++;
        if (lat != 3 || rlow != 3) begin
            miscompares++;
            $display("FAIL fetch_timing: got lat=%0d ready_low=%0d expected 3/3", lat, rlow);
        end
        vectors++;
        if (er !== 1'b0 || i !== 32'h8C220004 || m !== 32'h8C220004) begin
            miscompares++;
            $display("FAIL fetch_data: got err=%b instr=%h mdr=%h expected 0/8c220004/8c220004", er, i, m);
        end
    endtask

    task automatic test_store_load;
        int lat, rlow, nd;
        logic er, ee;
        logic [31:0] m, i;
        run_access(1, 1'b1, 1'b0, 32'h40, 32'h12345678, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b1, 1'b0, 32'h40, 32'h12345678, ee);
        vectors++;
        if (m !== mdr_m[1] || i !== instr_m[1]) begin
            miscompares++;
            $display("FAIL store_keeps_regs: got mdr=%h instr=%h expected %h/%h", m, i, mdr_m[1], instr_m[1]);
        end
        run_access(1, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b0, 1'b0, 32'h40, 32'd0, ee);
        vectors++;
        if (m !== 32'h12345678 || i !== instr_m[1]) begin
            miscompares++;
            $display("FAIL store_load: got mdr=%h instr=%h expected 12345678/%h", m, i, instr_m[1]);
        end
    endtask

    task automatic test_wrap_misalign;
        int lat, rlow, nd;
        logic er, ee;
        logic [31:0] m, i;
        run_access(1, 1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, ee);
        run_access(1, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b0, 1'b0, 32'h0, 32'd0, ee);
        vectors++;
        if (m !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL wrap: got %h expected a5a5a5a5", m);
        end
        run_access(1, 1'b0, 1'b1, 32'h41, 32'd0, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b0, 1'b1, 32'h41, 32'd0, ee);
        vectors++;
        if (er !== 1'b1 || lat != 3 || nd != 1) begin
            miscompares++;
            $display("FAIL misalign_err: got err=%b lat=%0d done=%0d expected 1/3/1", er, lat, nd);
        end
        vectors++;
        if (m !== mdr_m[1] || i !== instr_m[1]) begin
            miscompares++;
            $display("FAIL misalign_regs: got mdr=%h instr=%h expected %h/%h", m, i, mdr_m[1], instr_m[1]);
        end
    endtask

    task automatic test_handshake;
        int lat, rlow, nd;
        logic er, ee;
        logic [31:0] m, i, a, d;
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        d = $urandom;
        run_access(1, 1'b1, 1'b0, a, d, 1'b1, lat, rlow, nd, er, m, i);
        model_access(1, 1'b1, 1'b0, a, d, ee);
        vectors++;
        if (nd != 1 || lat != 3) begin
            miscompares++;
            $display("FAIL handshake_done: got done=%0d lat=%0d expected 1/3", nd, lat);
        end
        run_access(1, 1'b0, 1'b0, a, 32'd0, 1'b0, lat, rlow, nd, er, m, i);
        model_access(1, 1'b0, 1'b0, a, 32'd0, ee);
        vectors++;
        if (m !== d) begin
            miscompares++;
            $display("FAIL handshake_latched: got %h expected %h", m, d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [4];
        logic rdy, dn, e, ee, exp_dn, exp_rdy;
        logic [31:0] m, i;
        int dcount;
        for (int j = 0; j < 4; j++) a[j] = 32'($urandom_range(0, DEPTH - 1)) << 2;
        dcount = 0;
        drive(0, 1'b1, 1'b0, 1'b0, a[0], 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            sample(0, rdy, dn, e, m, i);
            exp_dn  = (k % 2 == 1) && (k <= 7);
            exp_rdy = !((k % 2 == 0) && (k <= 6));
            vectors++;
            if (dn !== exp_dn || rdy !== exp_rdy) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got done=%b ready=%b expected %b/%b", k, dn, rdy, exp_dn, exp_rdy);
            end
            if (dn === 1'b1 && exp_dn) begin
                dcount++;
                model_access(0, 1'b0, 1'b0, a[(k - 1) / 2], 32'd0, ee);
                vectors++;
                if (m !== mdr_m[0]) begin
                    miscompares++;
                    $display("FAIL b2b_mdr%0d: got %h expected %h", k, m, mdr_m[0]);
                end
            end else if (dn === 1'b1) begin
                dcount++;
            end
            if (k % 2 == 0 && k < 6) drive(0, 1'b1, 1'b0, 1'b0, a[k / 2 + 1], 32'd0);
            if (k == 6) drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        vectors++;
        if (dcount != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d done pulses expected 4", dcount);
        end
    endtask

    task automatic test_random;
        int lat, rlow, nd, s;
        logic er, ee, w, irw;
        logic [31:0] m, i, a, d;
        for (int n = 0; n < 60; n++) begin
            s   = $urandom_range(0, 1);
            w   = $urandom_range(0, 2) == 0;
            irw = $urandom_range(0, 1) == 1;
            a   = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            d   = $urandom;
            run_access(s, w, irw, a, d, $urandom_range(0, 3) == 0, lat, rlow, nd, er, m, i);
            model_access(s, w, irw, a, d, ee);
            vectors++;
            if (lat != lat_of(s) + 1 || rlow != lat_of(s) + 1 || nd != 1 || er !== ee) begin
                miscompares++;
                $display("FAIL rand%0d_ctl dut%0d: got lat=%0d rlow=%0d done=%0d err=%b expected %0d/%0d/1/%b",
                         n, s, lat, rlow, nd, er, lat_of(s) + 1, lat_of(s) + 1, ee);
            end
            vectors++;
            if (m !== mdr_m[s] || i !== instr_m[s]) begin
                miscompares++;
                $display("FAIL rand%0d_data dut%0d: got mdr=%h instr=%h expected %h/%h",
                         n, s, m, i, mdr_m[s], instr_m[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_reset_busy();
        test_fetch();
        test_store_load();
        test_wrap_misalign();
        test_handshake();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port.md
# mem_port

Shared instruction/data memory port for the multicycle MIPS core. It sits directly upstream of the control FSM and datapath and supplies the instruction register (IR) and memory data register (MDR) that the fetch and memory-read states consume. It accepts word stores from the memory-write state. The block models a RAM with a configurable number of wait states and exposes a ready/done handshake, so the control FSM holds its state until each access completes.

## Interface
- DEPTH, 256: RAM size in 32-bit words; power of two, 4..4096.
- LATENCY, 2: wait cycles inserted before each access; 0..15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only while ready=1.
- we  in  1  1 = store, 0 = load; qualified by req.
- ir_write  in  1  on a load, also load IR; ignored when we=1.
- addr  in  32  byte address (i_or_d-selected PC or ALUOut).
- wdata  in  32  store data (register B).
- ready  out  1  port idle, can accept req.
- done  out  1  one-cycle pulse: access finished this cycle.
- err  out  1  one-cycle pulse with done: access was misaligned.
- mdr  out  32  memory data register.
- instr  out  32  instruction register; op = instr[31:26], funct = instr[5:0].

## Operation
- Two states: IDLE and BUSY. ready = (state == IDLE), combinational from state only.
- Accept: at an edge with state=IDLE and req=1, the block:
  - latches addr, wdata, we, ir_write into internal registers;
  - loads wait counter cnt = LATENCY;
  - moves to BUSY.
- Later changes on the inputs do not affect an accepted access.
- BUSY, cnt != 0: decrement cnt at each edge.
- BUSY, cnt == 0: perform the access at that edge, go to IDLE, and register done=1 for the following cycle.
- Word index = latched addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Load: mdr <= RAM[index]. If ir_write=1, also instr <= RAM[index] at the same edge.
- Store: RAM[index] <= wdata. mdr and instr unchanged.
- Misaligned (latched addr[1:0] != 0):
  - no RAM write, mdr/instr unchanged;
  - completes with normal timing;
  - err=1 in the same cycle as done.
- req while BUSY: ignored; not queued.
- mdr and instr hold their value between accesses.

## Timing
- Reset (rst=1 at an edge) forces:
  - state=IDLE, cnt=0, done=0, err=0, mdr=0, instr=0;
  - ready=1 in the following cycle.
- RAM contents are not cleared by reset. Power-up RAM contents are undefined; the bench preloads them.
- Reset during BUSY: the pending access is cancelled, a pending store does not write RAM, and no done pulse is produced.
- Latency: accept at edge E0; access at edge E(LATENCY+1). done, err, updated mdr/instr and ready=1 are all visible in the cycle after E(LATENCY+1).
- LATENCY=0 gives single-cycle accesses: ready is low for exactly one cycle per access.
- Back-to-back: req held high while ready=1 in the done cycle is accepted at the next edge. Maximum throughput is one access per LATENCY+2 cycles.
- ready is low in every cycle spent in BUSY. The control FSM must not leave fetch or memory states until done=1.

## Test plan
- Reset: assert rst for 2 cycles during a BUSY store to addr 0x10 with wdata 0xDEADBEEF, LATENCY=2 -> ready=1, mdr=0, instr=0, no done pulse; a later load of 0x10 returns the preloaded value, not 0xDEADBEEF.
- Fetch: RAM[3]=0x8C220004, req=1, we=0, ir_write=1, addr=0x0C, LATENCY=2 -> ready low for 3 cycles; then done=1, err=0, instr=0x8C220004, mdr=0x8C220004.
- Store then load: store 0x12345678 to 0x40, then load from 0x40 with ir_write=0 -> mdr=0x12345678; instr keeps its previous value.
- Wrap and misalignment (DEPTH=256): store 0xA5A5A5A5 to 0x400 -> RAM[0] written. Load from 0x41 -> done and err pulse together; mdr unchanged.
- Handshake: toggle addr and wdata every cycle while BUSY, and pulse req mid-access -> the result uses the values latched at acceptance, and only one done pulse is produced.
- LATENCY=0 back-to-back: req held high for 4 loads -> one done every 2 cycles and 4 done pulses total.
